// File: rtl/oifs_pkg.sv
// Shared definitions for the OIFS (fast opto-isolated serial) link, used by
// both the receive and transmit interfaces.
package oifs_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FRAME_BITS = DATA_W_DEF + 2;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHAN  = 2'd2,
    STORE = 2'd3
  } oifs_state_e;

  // Frame length for a non-default payload width: start bit + payload + channel bit.
  function automatic int frame_bits(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/oifs_rx_fifo.sv
// Small synchronous show-ahead FIFO for the OIFS receiver; the head entry is
// visible on o_rdata whenever the FIFO is not empty.
module oifs_rx_fifo
  import oifs_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF + 1,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot in the same cycle, so a push into a full FIFO succeeds
  // when it coincides with a pop.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_wdata;
  end

  assign o_empty = (count == '0);
  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_rdata = o_empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/oifs_rx_interface.sv
// OIFS receive deframer: start(0) + DATA_W bits LSB first + channel bit, sampled on
// rising FSCLK. Define OIFS_RX_FIFO_EN to buffer in oifs_rx_fifo instead of one register.
module oifs_rx_interface
  import oifs_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_tick,
  input  logic              i_fsdo,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_channel,
  input  logic              i_ready,
  output logic              o_hold,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  oifs_state_e       state;
  oifs_state_e       state_n;
  logic [BCW-1:0]    bitcnt;
  logic [BCW-1:0]    bitcnt_n;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_n;
  logic              chan;
  logic              chan_n;
  logic              r_fsdo;
  logic              r_tick_d;
  logic              s;
  logic              push;
  logic              pop;
  logic              full;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_fsdo   <= 1'b1;
      r_tick_d <= 1'b0;
    end else begin
      r_fsdo   <= i_fsdo;
      r_tick_d <= i_tick;
    end
  end

  assign s = i_tick & ~r_tick_d;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      chan   <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      chan   <= chan_n;
    end
  end

  // Everything except STORE waits for a strobe, so a gated FSCLK freezes the frame.
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    chan_n   = chan;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (s && !r_fsdo) begin
          state_n  = DATA;
          bitcnt_n = '0;
        end
      end
      DATA: begin
        if (s) begin
          shreg_n  = {r_fsdo, shreg[DATA_W-1:1]};
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == BCW'(DATA_W - 1)) state_n = CHAN;
        end
      end
      CHAN: begin
        if (s) begin
          chan_n  = r_fsdo;
          state_n = STORE;
        end
      end
      STORE: begin
        push    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop    = o_valid & i_ready;
  assign o_busy = (state != IDLE);
  assign o_hold = full;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)                     o_overrun <= 1'b0;
    else if (push && full && !pop)  o_overrun <= 1'b1;
  end

`ifdef OIFS_RX_FIFO_EN
  logic [DATA_W:0] fifo_rdata;
  logic            fifo_empty;

  oifs_rx_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_push  (push),
    .i_wdata ({chan, shreg}),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_empty (fifo_empty),
    .o_full  (full)
  );

  assign o_valid   = ~fifo_empty;
  assign o_data    = fifo_rdata[DATA_W-1:0];
  assign o_channel = fifo_rdata[DATA_W];
`else
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              hold_chan;

  // Single holding register; a pop in the STORE cycle makes room for the new byte.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_chan  <= 1'b0;
    end else if (push && (!hold_valid || pop)) begin
      hold_valid <= 1'b1;
      hold_data  <= shreg;
      hold_chan  <= chan;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign o_valid   = hold_valid;
  assign o_data    = hold_data;
  assign o_channel = hold_chan;
  assign full      = hold_valid;
`endif

endmodule

// File: tb/tb_oifs_rx_interface.sv
// Self-checking bench for oifs_rx_interface: random frames against a queue model
// of the receive storage; honours OIFS_RX_FIFO_EN for the storage capacity.
module tb_oifs_rx_interface;
  import oifs_pkg::*;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef OIFS_RX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic              i_clk = 1'b0;
  logic              i_arst;
  logic              i_tick;
  logic              i_fsdo;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_channel;
  logic              i_ready;
  logic              o_hold;
  logic              o_overrun;
  logic              o_busy;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W:0] exp_q[$];
  logic            exp_overrun;

  oifs_rx_interface #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk     (i_clk),
    .i_arst    (i_arst),
    .i_tick    (i_tick),
    .i_fsdo    (i_fsdo),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_channel (o_channel),
    .i_ready   (i_ready),
    .o_hold    (o_hold),
    .o_overrun (o_overrun),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One FSCLK period (two i_clk cycles): data set while FSCLK low, sampled on its rise.
  task automatic sendBit(input logic b);
    @(negedge i_clk);
    i_fsdo = b;
    i_tick = 1'b0;
    @(negedge i_clk);
    i_tick = 1'b1;
  endtask

  task automatic modelStore(input logic [DATA_W-1:0] d, input logic ch);
    if (exp_q.size() < CAP) exp_q.push_back({ch, d});
    else                    exp_overrun = 1'b1;
  endtask

  // mode 0: i_ready low; mode 1: pulse i_ready during STORE; mode 2: i_ready held high
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic ch, input int mode);
    logic [DATA_W:0] head;
    sendBit(1'b0);
    for (int i = 0; i < DATA_W; i++) sendBit(d[i]);
    sendBit(ch);
    @(negedge i_clk);
    if (mode == 1) begin
      head = exp_q.pop_front();
      checkOutput("store_pop_data", {23'd0, o_channel, o_data}, {23'd0, head});
      i_ready = 1'b1;
      modelStore(d, ch);
      @(negedge i_clk);
      i_ready = 1'b0;
    end else if (mode == 2) begin
      checkOutput("latency_early", o_valid, 0);
      @(negedge i_clk);
      checkOutput("latency_valid", o_valid, 1);
      checkOutput("direct_data", o_data, d);
      checkOutput("direct_chan", o_channel, ch);
    end else begin
      checkOutput("latency_early", o_valid, exp_q.size() != 0);
      modelStore(d, ch);
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_fsdo = 1'b1;
    end
  endtask

  task automatic drainAll();
    logic [DATA_W:0] head;
    int waited;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (!o_valid && waited < 50) begin
        @(negedge i_clk);
        waited++;
      end
      checkOutput("drain_valid", o_valid, 1);
      head = exp_q.pop_front();
      checkOutput("drain_data", o_data, head[DATA_W-1:0]);
      checkOutput("drain_chan", o_channel, head[DATA_W]);
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
    end
    @(negedge i_clk);
    checkOutput("drain_empty", o_valid, 0);
    checkOutput("drain_hold", o_hold, 0);
  endtask

  task automatic fillStorage(input string tag);
    for (int i = 0; i < CAP; i++) begin
      applyStimulus(DATA_W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
      settle(2);
      checkOutput({tag, "_hold"}, o_hold, exp_q.size() == CAP);
    end
  endtask

  initial begin
    i_arst      = 1'b1;
    i_tick      = 1'b0;
    i_fsdo      = 1'b1;
    i_ready     = 1'b0;
    exp_overrun = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_valid", o_valid, 0);
    checkOutput("reset_data", o_data, 0);
    checkOutput("reset_chan", o_channel, 0);
    checkOutput("reset_hold", o_hold, 0);
    checkOutput("reset_overrun", o_overrun, 0);
    checkOutput("reset_busy", o_busy, 0);
    i_arst = 1'b0;
    settle(4);
    checkOutput("idle_busy", o_busy, 0);

    // Single frame delivered straight through with i_ready high.
    i_ready = 1'b1;
    applyStimulus(8'hA5, CH_B, 2);
    @(negedge i_clk);
    checkOutput("single_pulse_end", o_valid, 0);

    // Back-to-back frames with no idle bits between them.
    applyStimulus(8'h00, CH_A, 2);
    applyStimulus(8'hFF, CH_B, 2);
    settle(3);
    i_ready = 1'b0;
    checkOutput("b2b_overrun", o_overrun, 0);
    checkOutput("b2b_empty", o_valid, 0);

    // Fill storage until hold, then deliver everything in order.
    fillStorage("fill");
    checkOutput("fill_overrun", o_overrun, 0);
    drainAll();

    // Storage full while the consumer pops in the STORE cycle: no loss, no overrun.
    fillStorage("pushpop");
    applyStimulus(8'h99, CH_A, 1);
    settle(2);
    checkOutput("pushpop_overrun", o_overrun, exp_overrun);
    checkOutput("pushpop_hold", o_hold, 1);
    drainAll();

    // Extra frame into full storage is dropped and flagged.
    fillStorage("ovr");
    applyStimulus(8'h3C, CH_B, 0);
    settle(2);
    checkOutput("ovr_flag", o_overrun, exp_overrun);
    checkOutput("ovr_flag_set", o_overrun, 1);
    drainAll();
    checkOutput("ovr_sticky", o_overrun, 1);

    // Reset in the middle of a frame, then a clean frame.
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(i == 0);
    @(negedge i_clk);
    checkOutput("mid_busy", o_busy, 1);
    i_arst = 1'b1;
    #1;
    checkOutput("arst_busy", o_busy, 0);
    checkOutput("arst_overrun", o_overrun, 0);
    checkOutput("arst_valid", o_valid, 0);
    checkOutput("arst_hold", o_hold, 0);
    @(negedge i_clk);
    i_arst      = 1'b0;
    i_tick      = 1'b0;
    i_fsdo      = 1'b1;
    exp_overrun = 1'b0;
    exp_q.delete();
    settle(3);
    applyStimulus(8'h42, CH_A, 0);
    settle(2);
    drainAll();
    checkOutput("post_reset_overrun", o_overrun, 0);

    // A few more random frames, consumer held off for a while.
    for (int r = 0; r < 3; r++) begin
      applyStimulus(DATA_W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
      settle(2);
    end
    checkOutput("rand_overrun", o_overrun, exp_overrun);
    drainAll();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
